rr_arbiter_n: RTL



---
 rtl/rr_arbiter_n.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter over N_REQ requestors with a per-grantee burst allowance
// and a lock input that keeps ownership for multi-flit packets.
// The grant is combinational from req_i and registered state. State moves only
// when a grant is consumed (update_i), except that a lock is abandoned when its
// owner stops requesting.
module rr_arbiter_n #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned BURST = 1,
  localparam int unsigned IDX_W = $clog2(N_REQ),
  localparam int unsigned CNT_W = $clog2(BURST) + 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             lock_i,
  input  logic             update_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             grant_vld_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [N_REQ-1:0] r_mask;
  logic             r_locked;
  logic [IDX_W-1:0] r_owner;
  logic [CNT_W-1:0] r_burst_cnt;

  logic [N_REQ-1:0] w_masked;
  logic [N_REQ-1:0] w_cand;
  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_lock_hit;

  logic [N_REQ-1:0] w_mask_nxt;
  logic             w_locked_nxt;
  logic [IDX_W-1:0] w_owner_nxt;
  logic [CNT_W-1:0] w_burst_cnt_nxt;
  logic [CNT_W:0]   w_n;
  logic [N_REQ-1:0] w_mask_above;
  logic [N_REQ-1:0] w_mask_ge;

  // Grant selection: lock owner first, then the masked set, then wrap to the full set.
  always_comb begin
    w_masked   = req_i & r_mask;
    w_lock_hit = r_locked && req_i[r_owner];
    w_cand     = '0;
    if (w_lock_hit) begin
      w_cand[r_owner] = 1'b1;
    end else if (|w_masked) begin
      w_cand = w_masked;
    end else begin
      w_cand = req_i;
    end
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_cand[k] && !w_found) begin
        w_grant[k] = 1'b1;
        w_idx      = IDX_W'(k);
        w_found    = 1'b1;
      end
    end
    // Outputs are silenced for the whole reset window.
    if (arst) begin
      w_grant = '0;
      w_idx   = '0;
    end
  end

  assign grant_o     = w_grant;
  assign grant_vld_o = |w_grant;
  assign grant_idx_o = w_idx;

  // Next state: accepted transfers rotate or extend priority, idle cycles may abandon a lock.
  always_comb begin
    w_mask_nxt      = r_mask;
    w_locked_nxt    = r_locked;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = r_burst_cnt;
    w_n = (w_idx == r_owner) ? ({1'b0, r_burst_cnt} + (CNT_W+1)'(1)) : (CNT_W+1)'(1);
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_mask_above[k] = (IDX_W'(k) > w_idx) || (w_idx == IDX_W'(N_REQ - 1));
      w_mask_ge[k]    = (IDX_W'(k) >= w_idx);
    end
    if (update_i && grant_vld_o) begin
      w_owner_nxt = w_idx;
      if (lock_i) begin
        // Locked transfers neither rotate nor consume burst.
        w_locked_nxt = 1'b1;
      end else begin
        w_locked_nxt = 1'b0;
        if (w_n >= (CNT_W+1)'(BURST)) begin
          w_mask_nxt      = w_mask_above;
          w_burst_cnt_nxt = '0;
        end else begin
          w_mask_nxt      = w_mask_ge;
          w_burst_cnt_nxt = w_n[CNT_W-1:0];
        end
      end
    end else if (!update_i && r_locked && !w_lock_hit) begin
      w_locked_nxt = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (arst) begin
      r_mask      <= '1;
      r_locked    <= 1'b0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_mask      <= w_mask_nxt;
      r_locked    <= w_locked_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

endmodule
